// File: rtl/line_buf_ctrl_pkg.sv
// Shared types and derived frame constants for the line-buffer controller.
package lbm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    // Push count at which the taps first hold a full 3-row window.
    function automatic int unsigned FILL_LEN(input int unsigned w);
        return 3 * w;
    endfunction

    function automatic int unsigned LAST_IN(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    function automatic int unsigned LAST_PUSH(input int unsigned w, input int unsigned h);
        return w * h + w - 1;
    endfunction

endpackage

// File: rtl/line_buf_ctrl_if.sv
// Pixel-in, line-buffer shift and window-out signals of the line-buffer controller.
interface line_buf_ctrl_if #(
    parameter int SCREEN_WIDTH  = 8,
    parameter int SCREEN_HEIGHT = 4,
    parameter int N_BITS        = 15
);
    localparam int CW = $clog2(SCREEN_WIDTH);
    localparam int RW = $clog2(SCREEN_HEIGHT);

    logic [N_BITS-1:0] pix_in;
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] buf_d;
    logic              buf_en_n;
    logic              win_valid;
    logic              win_ready;
    logic [CW-1:0]     win_col;
    logic [RW-1:0]     win_row;

    modport master (
        input  pix_in, in_valid, win_ready,
        output in_ready, buf_d, buf_en_n, win_valid, win_col, win_row
    );

    modport slave (
        output pix_in, in_valid, win_ready,
        input  in_ready, buf_d, buf_en_n, win_valid, win_col, win_row
    );

endinterface

// File: rtl/line_buf_ctrl.sv
// Sequences one frame of pixels into an external line buffer and flags when
// its three taps form a valid window, with window coordinates and handshake.
module line_buf_ctrl
    import lbm_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 8,
    parameter int SCREEN_HEIGHT = 4,
    parameter int N_BITS        = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    line_buf_ctrl_if.master     lb,
    output logic                busy,
    output logic                frame_done
);
    localparam int unsigned PW = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT + SCREEN_WIDTH);
    localparam int unsigned CW = $clog2(SCREEN_WIDTH);
    localparam int unsigned RW = $clog2(SCREEN_HEIGHT);

    localparam logic [PW-1:0] P_FILL      = PW'(FILL_LEN(SCREEN_WIDTH));
    localparam logic [PW-1:0] P_LAST_IN   = PW'(LAST_IN(SCREEN_WIDTH, SCREEN_HEIGHT));
    localparam logic [PW-1:0] P_LAST_PUSH = PW'(LAST_PUSH(SCREEN_WIDTH, SCREEN_HEIGHT));
    localparam logic [CW-1:0] COL_LAST    = CW'(SCREEN_WIDTH - 1);

    state_t        state, state_nxt;
    logic [PW-1:0] p, p_inc;
    logic          permit;
    logic          push;

    always_comb begin
        state_nxt   = state;
        p_inc       = p + PW'(1);
        permit      = !lb.win_valid || lb.win_ready;
        push        = 1'b0;
        lb.in_ready = 1'b0;
        lb.buf_d    = '0;
        busy        = 1'b0;
        frame_done  = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_nxt = FILL;
            end
            FILL, STREAM: begin
                busy        = 1'b1;
                lb.in_ready = permit;
                lb.buf_d    = lb.pix_in;
                push        = lb.in_valid && permit;
                // With H == 3 the fill-complete push is also the last input push.
                if (push) begin
                    if (p_inc == P_LAST_IN)   state_nxt = FLUSH;
                    else if (p_inc == P_FILL) state_nxt = STREAM;
                end
            end
            FLUSH: begin
                busy = 1'b1;
                push = permit;
                if (push && p_inc == P_LAST_PUSH) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        lb.buf_en_n = !push;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            p            <= '0;
            lb.win_col   <= '0;
            lb.win_row   <= '0;
            lb.win_valid <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && start) begin
                p          <= '0;
                lb.win_col <= '0;
                lb.win_row <= '0;
            end else if (push) begin
                p <= p_inc;
                if (p >= P_FILL) begin
                    if (lb.win_col == COL_LAST) begin
                        lb.win_col <= '0;
                        lb.win_row <= lb.win_row + RW'(1);
                    end else begin
                        lb.win_col <= lb.win_col + CW'(1);
                    end
                end
            end

            // A push that lands in the window range replaces the consumed window.
            if (push && p_inc >= P_FILL && p_inc <= P_LAST_PUSH)
                lb.win_valid <= 1'b1;
            else if (lb.win_valid && lb.win_ready)
                lb.win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed-step bench for line_buf_ctrl at W=8, H=4: full frames, window stall,
// gapped input, ignored start and mid-frame reset.
module tb_line_buf_ctrl;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int NB = 15;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic frame_done;

    int vectors     = 0;
    int miscompares = 0;
    int next_pix    = 0;

    line_buf_ctrl_if #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .N_BITS(NB)) lb ();

    line_buf_ctrl #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .N_BITS       (NB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .lb        (lb),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"},       32'(busy),         32'd0);
        check({tag, " frame_done"}, 32'(frame_done),   32'd0);
        check({tag, " in_ready"},   32'(lb.in_ready),  32'd0);
        check({tag, " buf_en_n"},   32'(lb.buf_en_n),  32'd1);
        check({tag, " buf_d"},      32'(lb.buf_d),     32'd0);
        check({tag, " win_valid"},  32'(lb.win_valid), 32'd0);
        check({tag, " win_col"},    32'(lb.win_col),   32'd0);
        check({tag, " win_row"},    32'(lb.win_row),   32'd0);
    endtask

    // Runs one frame from a start pulse; optional window stall, start-during-frame
    // or reset abort, each triggered when window number N is presented.
    task automatic run_frame(input string nm, input bit toggle, input int stall_win,
                             input int start_win, input int abort_win);
        int pushes = 0, flushes = 0, wins = 0, dones = 0, cyc = 0, stall_left = 0;
        bit first_seen = 0, stalled = 0, started = 0, finished = 0;
        logic [31:0] hold_col = '0, hold_row = '0;
        logic in_phase, permit, exp_push;

        lb.in_valid  = 1'b0;
        lb.win_ready = 1'b1;
        start        = 1'b1;
        #1;
        check({nm, " idle in_ready"}, 32'(lb.in_ready),  32'd0);
        check({nm, " idle buf_en_n"}, 32'(lb.buf_en_n),  32'd1);
        check({nm, " idle busy"},     32'(busy),         32'd0);
        check({nm, " idle win_valid"},32'(lb.win_valid), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check({nm, " busy after start"}, 32'(busy), 32'd1);

        while (!finished && cyc < 300) begin
            lb.in_valid = (toggle && pushes < 3 * W) ? (cyc % 2 == 0) : 1'b1;
            lb.pix_in   = NB'(next_pix);
            if (stall_win >= 0 && !stalled && lb.win_valid && wins == stall_win) begin
                stalled    = 1;
                stall_left = 5;
                hold_col   = 32'(lb.win_col);
                hold_row   = 32'(lb.win_row);
            end
            lb.win_ready = (stall_left == 0);
            start = (start_win >= 0 && !started && lb.win_valid && wins == start_win);
            if (start) started = 1;

            if (abort_win >= 0 && lb.win_valid && wins == abort_win) begin
                reset = 1'b1;
                #1;
                check_reset_outputs({nm, " async"});
                @(posedge clk); #1;
                check_reset_outputs({nm, " after edge"});
                reset = 1'b0;
                start = 1'b0;
                return;
            end
            #1;

            in_phase = pushes < W * H;
            permit   = !lb.win_valid || lb.win_ready;
            exp_push = permit && (in_phase ? lb.in_valid : (flushes < W - 1));
            check({nm, " in_ready"},   32'(lb.in_ready),  32'(in_phase && permit));
            check({nm, " buf_en_n"},   32'(lb.buf_en_n),  32'(!exp_push));
            check({nm, " busy"},       32'(busy),         32'(flushes < W - 1));
            check({nm, " frame_done"}, 32'(frame_done),   32'(flushes == W - 1));

            if (stall_left > 0) begin
                check({nm, " stall win_valid"}, 32'(lb.win_valid), 32'd1);
                check({nm, " stall win_col"},   32'(lb.win_col),   hold_col);
                check({nm, " stall win_row"},   32'(lb.win_row),   hold_row);
                stall_left--;
            end

            if (lb.win_valid && !first_seen) begin
                first_seen = 1;
                check({nm, " pushes before first window"}, 32'(pushes), 32'(3 * W));
            end

            if (!lb.buf_en_n) begin
                if (in_phase) begin
                    check({nm, " buf_d pixel"}, 32'(lb.buf_d), 32'(NB'(next_pix)));
                    pushes++;
                    next_pix++;
                end else begin
                    check({nm, " buf_d flush"}, 32'(lb.buf_d), 32'd0);
                    flushes++;
                end
            end

            if (lb.win_valid && lb.win_ready) begin
                check({nm, " window index"}, 32'(lb.win_row) * W + 32'(lb.win_col), 32'(wins));
                wins++;
            end

            if (frame_done) begin
                dones++;
                finished = 1;
            end

            @(posedge clk); #1;
            cyc++;
        end

        check({nm, " windows"},      32'(wins),         32'((H - 2) * W));
        check({nm, " data pushes"},  32'(pushes),       32'(W * H));
        check({nm, " flush pushes"}, 32'(flushes),      32'(W - 1));
        check({nm, " frame_done count"}, 32'(dones),    32'd1);
        check({nm, " end busy"},     32'(busy),         32'd0);
        check({nm, " end win_valid"},32'(lb.win_valid), 32'd0);
        check({nm, " end frame_done"},32'(frame_done),  32'd0);
        check({nm, " end buf_en_n"}, 32'(lb.buf_en_n),  32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        lb.in_valid  = 1'b0;
        lb.win_ready = 1'b1;
        lb.pix_in    = '0;

        @(posedge clk); #1;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        check_reset_outputs("reset held");
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle without start busy", 32'(busy), 32'd0);

        run_frame("basic",         1'b0, -1, -1, -1);
        run_frame("stall",         1'b0,  3, -1, -1);
        run_frame("toggle",        1'b1, -1, -1, -1);
        run_frame("start_ignored", 1'b0, -1,  5, -1);
        run_frame("abort",         1'b0, -1, -1,  4);
        run_frame("after_reset",   1'b0, -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/line_buf_ctrl.md
LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 8, meaning pixels per row (W, >=2).
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 4, meaning rows per frame (H, >=3).
REQ-003 SHALL have parameter N_BITS, default 15, meaning pixel word width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle frame start request.
REQ-007 SHALL have port pix_in  input  N_BITS  upstream pixel.
REQ-008 SHALL have port in_valid  input  1  upstream pixel valid.
REQ-009 SHALL have port in_ready  output  1  controller accepts pix_in.
REQ-010 SHALL have port buf_d  output  N_BITS  data into the line-buffer shift register.
REQ-011 SHALL have port buf_en_n  output  1  active-low shift enable to the line buffer (0 = shift this cycle).
REQ-012 SHALL have port win_valid  output  1  line-buffer taps hold a complete 3-row window.
REQ-013 SHALL have port win_ready  input  1  downstream consumes the window.
REQ-014 SHALL have ports win_col and win_row  output  $clog2(W) and $clog2(H)  coordinates of the tap0 pixel of the presented window.
REQ-015 SHALL have ports busy (frame in progress) and frame_done (one-cycle pulse)  output  1 each.

Function
REQ-016 SHALL implement states IDLE, FILL, STREAM, FLUSH, DONE.
REQ-017 SHALL count pushes p (shifts since frame start); tap0/tap1/tap2 hold pixels p-3W, p-2W, p-W.
REQ-018 SHALL define push = (buf_en_n==0); push permitted only when (!win_valid || win_ready).
REQ-019 SHALL in FILL/STREAM drive in_ready = permit, buf_d = pix_in, buf_en_n = !(in_valid && in_ready).
REQ-020 SHALL in FLUSH drive in_ready = 0, buf_d = 0, buf_en_n = !permit.
REQ-021 SHALL in IDLE/DONE drive in_ready = 0, buf_en_n = 1.
REQ-022 SHALL transition IDLE->FILL on start, clearing p, win_col, win_row.
REQ-023 SHALL transition FILL->STREAM on the push making p = 3W; STREAM->FLUSH on the push making p = W*H; FLUSH->DONE on the push making p = W*H+W-1; DONE->IDLE unconditionally.
REQ-024 SHALL register win_valid: set on any push yielding p in [3W, W*H+W-1]; cleared on win_valid && win_ready without push; held otherwise.
REQ-025 SHALL emit exactly (H-2)*W windows per frame, none lost or duplicated under any win_ready pattern.
REQ-026 SHALL advance win_col on each push with p already >= 3W, wrapping W-1 -> 0 and then incrementing win_row.
REQ-027 SHALL pulse frame_done for the single cycle in DONE; busy = 1 in FILL, STREAM, FLUSH.
REQ-028 SHALL ignore start when not in IDLE.
REQ-029 SHALL size p as $clog2(W*H+W) bits; no counter may wrap within a frame.

Reset
REQ-030 SHALL on reset (any time, including mid-frame) go to IDLE with p, win_col, win_row = 0, win_valid = 0, frame_done = 0, busy = 0, buf_en_n = 1, in_ready = 0, buf_d = 0.
REQ-031 SHALL NOT clear line-buffer contents; stale contents are harmless because win_valid restarts only after 3W new pushes.

Structure
REQ-032 SHALL place the state enum and derived constants (FILL_LEN = 3W, LAST_IN = W*H, LAST_PUSH = W*H+W-1) in shared package lbm_pkg.
REQ-033 SHALL be a single module without sub-modules; the line buffer is instantiated beside it, not inside it.

Verification (W=8, H=4, win_ready=1 unless stated)
REQ-034 SHALL check start, 32 pixels with in_valid=1 -> 24 fill pushes, win_valid first high on cycle after push 24, 7 flush pushes with buf_d=0, 16 windows total, frame_done once.
REQ-035 SHALL check window coordinates -> first window (col 0,row 0), last (col 7,row 1); tap0 pixel index = row*8+col.
REQ-036 SHALL check win_ready=0 for 5 cycles at window 3 -> in_ready=0 and buf_en_n=1 throughout, window 3 held stable, no loss.
REQ-037 SHALL check in_valid toggling 1010 during FILL -> pushes only on high cycles, p matches accepted count.
REQ-038 SHALL check reset asserted mid-STREAM -> IDLE next edge, all outputs at reset values; a new start yields a full 16-window frame.
REQ-039 SHALL check start during STREAM -> ignored, frame completes normally.
